// File: rtl/cisr_row_scheduler.sv
// CISR row scheduler: hands CSR row lengths to the lowest free channel.
// Build option CISR_SCHED_ZERO_SKIP_EN drops zero-length rows without a channel.
module cisr_row_scheduler #(
    parameter int NCH   = 4,
    parameter int LEN_W = 5,
    parameter int ID_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ID_W-1:0]     num_rows,
    input  logic [LEN_W-1:0]    len_data,
    input  logic                len_valid,
    output logic                len_ready,
    input  logic                stall,
    output logic [NCH-1:0]      ch_valid,
    output logic [NCH*ID_W-1:0] ch_row_id,
    output logic [NCH-1:0]      ch_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [ID_W-1:0]  rows_q;
    logic [ID_W-1:0]  next_id;
    logic [NCH-1:0]   active;
    logic [LEN_W-1:0] remaining [NCH];
    logic [ID_W-1:0]  row_id    [NCH];

    logic [NCH-1:0]   free;
    logic [NCH-1:0]   sel;
    logic             any_free;
    logic             rows_left;
    logic             zero_len;
    logic             accept;
    logic             load;
    logic [LEN_W-1:0] load_len;

    // A channel on its final element can take a new row with no bubble.
    always_comb begin
        free = '0;
        for (int i = 0; i < NCH; i++) begin
            free[i] = !active[i] || (remaining[i] == LEN_W'(1));
        end
    end

    always_comb begin
        sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (free[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

    assign any_free  = |free;
    assign rows_left = next_id < rows_q;
    assign zero_len  = (len_data == '0);
    assign accept    = len_valid && len_ready;

`ifdef CISR_SCHED_ZERO_SKIP_EN
    assign len_ready = (state == RUN) && !stall && rows_left
                       && (any_free || zero_len);
    assign load      = accept && !zero_len;
    assign load_len  = len_data;
`else
    assign len_ready = (state == RUN) && !stall && rows_left && any_free;
    assign load      = accept;
    assign load_len  = zero_len ? LEN_W'(1) : len_data;
`endif

    assign ch_valid = active & {NCH{!stall}};
    assign busy     = (state == RUN) || (state == DRAIN);

    always_comb begin
        ch_last   = '0;
        ch_row_id = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_last[i] = ch_valid[i] && (remaining[i] == LEN_W'(1));
            ch_row_id[i*ID_W +: ID_W] = row_id[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rows_q  <= '0;
            next_id <= '0;
            active  <= '0;
            done    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                remaining[i] <= '0;
                row_id[i]    <= '0;
            end
        end else begin
            done <= !stall && (state == DONE);
            if (!stall) begin
                for (int i = 0; i < NCH; i++) begin
                    if (ch_valid[i]) begin
                        remaining[i] <= remaining[i] - LEN_W'(1);
                        if (ch_last[i]) begin
                            active[i] <= 1'b0;
                        end
                    end
                    if (load && sel[i]) begin
                        row_id[i]    <= next_id;
                        remaining[i] <= load_len;
                        active[i]    <= 1'b1;
                    end
                end
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            rows_q  <= num_rows;
                            next_id <= '0;
                            state   <= (num_rows == '0) ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            next_id <= next_id + ID_W'(1);
                        end
                        if (next_id == rows_q) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (active == '0) begin
                            state <= DONE;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cisr_row_scheduler.sv
// Bench for cisr_row_scheduler: per-cycle expectations and per-channel
// element scoreboard from a row-level model of the scheduling rules.
module tb_cisr_row_scheduler;

    localparam int NCH   = 4;
    localparam int LEN_W = 5;
    localparam int ID_W  = 8;
`ifdef CISR_SCHED_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [ID_W-1:0]     num_rows = '0;
    logic [LEN_W-1:0]    len_data = '0;
    logic                len_valid = 1'b0;
    logic                len_ready;
    logic                stall = 1'b0;
    logic [NCH-1:0]      ch_valid;
    logic [NCH*ID_W-1:0] ch_row_id;
    logic [NCH-1:0]      ch_last;
    logic                busy;
    logic                done;

    cisr_row_scheduler #(.NCH(NCH), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_rows(num_rows),
        .len_data(len_data),
        .len_valid(len_valid),
        .len_ready(len_ready),
        .stall(stall),
        .ch_valid(ch_valid),
        .ch_row_id(ch_row_id),
        .ch_last(ch_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           skip;
        logic           rdy;
        logic           busy;
        logic           done;
        logic [NCH-1:0] v;
        logic [NCH-1:0] last;
    } exp_t;

    typedef struct {
        int              ch;
        logic [ID_W-1:0] id;
        bit              last;
    } elem_t;

    exp_t  expq[$];
    elem_t chq[$];
    int    lens[$];

    int ntests = 0;
    int nfail  = 0;

    // Row-level model of the scheduler
    int ph = P_IDLE;
    int nrows = 0;
    int issued = 0;
    int left[NCH];
    bit mdone = 1'b0;
    int cur_n = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic match(input int i);
        int idx;
        idx = -1;
        foreach (chq[k]) begin
            if (idx < 0 && chq[k].ch == i) idx = k;
        end
        if (idx < 0) begin
            ntests++;
            nfail++;
            $display("FAIL emit_ch%0d: actual row_id=%0d, required no emission",
                     i, ch_row_id[i*ID_W +: ID_W]);
        end else begin
            chk($sformatf("row_id_ch%0d", i),
                ch_row_id[i*ID_W +: ID_W], chq[idx].id);
            chk($sformatf("last_ch%0d", i), ch_last[i], chq[idx].last);
            chq.delete(idx);
        end
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_ch_valid"}, ch_valid, 0);
        chk({tag, "_ch_last"}, ch_last, 0);
        chk({tag, "_ch_row_id"}, ch_row_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_len_ready"}, len_ready, 0);
    endtask

    task automatic step();
        exp_t  e;
        elem_t el;
        int    c;
        int    ln;
        bit    anyfree;
        bit    acc;
        bit    to_drain;
        bit    all_idle;
        e = '0;
        if (reset) begin
            e.skip = 1'b1;
            expq.push_back(e);
            ph = P_IDLE;
            nrows = 0;
            issued = 0;
            mdone = 1'b0;
            for (int i = 0; i < NCH; i++) left[i] = 0;
            chq.delete();
            return;
        end
        c = -1;
        anyfree = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (left[i] <= 1) begin
                anyfree = 1'b1;
                if (c < 0) c = i;
            end
        end
        e.rdy = (ph == P_RUN) && !stall && (issued < nrows)
                && (anyfree || (ZS && len_data == 0));
        e.busy = (ph == P_RUN) || (ph == P_DRAIN);
        e.done = mdone;
        for (int i = 0; i < NCH; i++) begin
            e.v[i] = (left[i] > 0) && !stall;
            e.last[i] = e.v[i] && (left[i] == 1);
        end
        expq.push_back(e);
        mdone = (ph == P_DONE) && !stall;
        if (stall) return;
        acc = e.rdy && len_valid;
        to_drain = (ph == P_RUN) && (issued == nrows);
        all_idle = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (left[i] > 0) begin
                all_idle = 1'b0;
                left[i]--;
            end
        end
        if (acc) begin
            if (!(ZS && len_data == 0)) begin
                ln = (len_data == 0) ? 1 : int'(len_data);
                left[c] = ln;
                for (int k = 0; k < ln; k++) begin
                    el.ch = c;
                    el.id = ID_W'(issued);
                    el.last = (k == ln - 1);
                    chq.push_back(el);
                end
            end
            issued++;
        end
        case (ph)
            P_IDLE: begin
                if (start) begin
                    nrows = int'(num_rows);
                    issued = 0;
                    ph = (nrows == 0) ? P_DONE : P_RUN;
                end
            end
            P_RUN:   if (to_drain) ph = P_DRAIN;
            P_DRAIN: if (all_idle) ph = P_DONE;
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic cycle(input bit st, input bit rs, input bit stl, input bit lv);
        @(negedge clk);
        start = st;
        reset = rs;
        stall = stl;
        len_valid = lv;
        num_rows = ID_W'(cur_n);
        if (issued < lens.size()) len_data = LEN_W'(lens[issued]);
        else len_data = LEN_W'($urandom);
        step();
    endtask

    task automatic run_matrix(input int n, input int vpct, input int spct,
                              input int s0, input int abort_at);
        int k;
        bit st;
        bit lv;
        cur_n = n;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        k = 1;
        while (!(ph == P_IDLE && !mdone)) begin
            if (k == abort_at) begin
                cycle(1'b0, 1'b1, 1'b0, 1'b0);
                cycle(1'b0, 1'b0, 1'b0, 1'b0);
                #2;
                zero_check("mid_reset");
                return;
            end
            if (k > 200 + 40 * n) begin
                ntests++;
                nfail++;
                $display("FAIL timeout: actual %0d cycles, required completion", k);
                return;
            end
            if (s0 >= 0) st = (k >= s0) && (k < s0 + 3);
            else st = ($urandom_range(99) < spct);
            lv = ($urandom_range(99) < vpct);
            cycle(1'b0, 1'b0, st, lv);
            k++;
        end
        #3;
        chk("rows_emitted_pending", chq.size(), 0);
    endtask

    exp_t me;
    always @(negedge clk) begin
        #2;
        if (expq.size() != 0) begin
            me = expq.pop_front();
            if (!me.skip) begin
                chk("len_ready", len_ready, me.rdy);
                chk("busy", busy, me.busy);
                chk("done", done, me.done);
                chk("ch_valid", ch_valid, me.v);
                chk("ch_last", ch_last, me.last);
                for (int i = 0; i < NCH; i++) begin
                    if (ch_valid[i]) match(i);
                end
            end
        end
    end

    initial begin
        int n;
        int r;
        for (int i = 0; i < NCH; i++) left[i] = 0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        zero_check("reset");

        lens = '{3, 1, 2, 2};
        run_matrix(4, 100, 0, -1, 0);
        lens = '{1, 1, 1, 1, 1, 1};
        run_matrix(6, 100, 0, -1, 0);
        lens = '{4, 4, 4};
        run_matrix(3, 100, 0, 3, 0);
        lens = '{2, 0, 2};
        run_matrix(3, 100, 0, -1, 0);
        lens = '{10, 10, 10, 10};
        run_matrix(4, 100, 0, -1, 6);
        lens = '{3, 1, 2, 2};
        run_matrix(4, 100, 0, -1, 0);
        lens.delete();
        run_matrix(0, 100, 0, -1, 0);

        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(12, 1);
            lens.delete();
            for (int j = 0; j < n; j++) begin
                r = $urandom_range(5);
                if (r == 0) lens.push_back(0);
                else if (t % 3 == 0) lens.push_back($urandom_range(31, 1));
                else lens.push_back($urandom_range(6, 1));
            end
            run_matrix(n, 70, 25, -1, 0);
        end

        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("final_elem_queue", chq.size(), 0);
        chk("final_exp_queue", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
